// File: rtl/sumador_32bit.sv
// Registered WIDTH-bit adder built from 4-bit carry-lookahead groups with rippled group carries.
// Optional registered overflow/zero/negative flags when SUMADOR_FLAGS_EN is defined.
module sumador_32bit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] datoA,
    input  logic [WIDTH-1:0] datoB,
    input  logic             carryIn,
    output logic [WIDTH-1:0] resultado,
    output logic             carryOut
`ifdef SUMADOR_FLAGS_EN
    ,
    output logic             overflow,
    output logic             zero,
    output logic             negative
`endif
);

    localparam int unsigned NGROUPS = WIDTH / 4;

    // Returns {c4, sum[3:0]} for one 4-bit lookahead group.
    function automatic logic [4:0] claGroup(
        input logic [3:0] a,
        input logic [3:0] b,
        input logic       cin
    );
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        return {c[4], p ^ c[3:0]};
    endfunction

    logic [WIDTH-1:0] sumComb;
    logic             carryChain;
    logic [4:0]       grpOut;

    always_comb begin
        sumComb    = '0;
        carryChain = carryIn;
        grpOut     = '0;
        for (int unsigned i = 0; i < NGROUPS; i++) begin
            grpOut             = claGroup(datoA[4*i +: 4], datoB[4*i +: 4], carryChain);
            sumComb[4*i +: 4]  = grpOut[3:0];
            carryChain         = grpOut[4];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resultado <= '0;
            carryOut  <= 1'b0;
        end else begin
            resultado <= sumComb;
            carryOut  <= carryChain;
        end
    end

`ifdef SUMADOR_FLAGS_EN
    logic overflowNext;

    always_comb begin
        overflowNext = (datoA[WIDTH-1] == datoB[WIDTH-1]) &&
                       (sumComb[WIDTH-1] != datoA[WIDTH-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
        end else begin
            overflow <= overflowNext;
            zero     <= (sumComb == '0);
            negative <= sumComb[WIDTH-1];
        end
    end
`endif

endmodule

// File: tb/tb_sumador_32bit.sv
// Scoreboard bench for sumador_32bit: expected results queued at drive time, popped one cycle later.
// Flag checks are compiled in when SUMADOR_FLAGS_EN is defined.
module tb_sumador_32bit;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] datoA;
    logic [W-1:0] datoB;
    logic         carryIn;
    logic [W-1:0] resultado;
    logic         carryOut;
`ifdef SUMADOR_FLAGS_EN
    logic         overflow;
    logic         zero;
    logic         negative;
`endif

    int errors = 0;
    int checks = 0;

    // Entry layout: {overflow, carryOut, resultado}
    logic [W+1:0] q[$];

    sumador_32bit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .datoA     (datoA),
        .datoB     (datoB),
        .carryIn   (carryIn),
        .resultado (resultado),
        .carryOut  (carryOut)
`ifdef SUMADOR_FLAGS_EN
        ,
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic pushOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic [W-1:0] expRes, input logic expCo, input logic expOv);
        @(negedge clk);
        datoA   = a;
        datoB   = b;
        carryIn = cin;
        q.push_back({expOv, expCo, expRes});
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            datoA   = $urandom;
            datoB   = $urandom;
            carryIn = 1'(i);
            @(posedge clk);
            #1;
            checks++;
            if (resultado !== '0 || carryOut !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: resultado=%h carryOut=%b, required 0/0", resultado, carryOut);
            end
`ifdef SUMADOR_FLAGS_EN
            checks++;
            if ({overflow, zero, negative} !== 3'b000) begin
                errors++;
                $display("FAIL reset_flags: ovf/zero/neg=%b, required 000", {overflow, zero, negative});
            end
`endif
        end
        // Release between edges: outputs must stay 0 until the next rising edge.
        @(negedge clk);
        datoA   = 45;
        datoB   = 45;
        carryIn = 1'b0;
        rst_n   = 1'b1;
        #1;
        checks++;
        if (resultado !== '0 || carryOut !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_hold: resultado=%h carryOut=%b, required 0/0", resultado, carryOut);
        end
        @(posedge clk);
        #1;
        checks++;
        if (resultado !== 32'd90 || carryOut !== 1'b0) begin
            errors++;
            $display("FAIL first_after_reset: resultado=%0d carryOut=%b, required 90/0", resultado, carryOut);
        end
    endtask

    task automatic runDirected(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, input logic [W-1:0] expRes, input logic expCo,
                               input logic expOv);
        logic [W+1:0] e;
        pushOp(a, b, cin, expRes, expCo, expOv);
        @(posedge clk);
        #1;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL %s_queue: scoreboard empty, required one entry", name);
        end else begin
            e = q.pop_front();
            if (resultado !== e[W-1:0] || carryOut !== e[W]) begin
                errors++;
                $display("FAIL %s: resultado=%h carryOut=%b, required %h/%b",
                         name, resultado, carryOut, e[W-1:0], e[W]);
            end
`ifdef SUMADOR_FLAGS_EN
            checks++;
            if (overflow !== e[W+1] || zero !== (e[W-1:0] == '0) || negative !== e[W-1]) begin
                errors++;
                $display("FAIL %s_flags: ovf/zero/neg=%b%b%b, required %b%b%b", name,
                         overflow, zero, negative, e[W+1], (e[W-1:0] == '0), e[W-1]);
            end
`endif
        end
    endtask

    task automatic test_basic();
        runDirected("add_45_45",     32'd45,    32'd45,      1'b0, 32'd90,      1'b0, 1'b0);
        runDirected("add_0_325",     32'd0,     32'd325,     1'b0, 32'd325,     1'b0, 1'b0);
        runDirected("add_23845",     32'd23845, 32'd5645,    1'b0, 32'd29490,   1'b0, 1'b0);
        runDirected("add_1_425",     32'd1,     32'd425,     1'b0, 32'd426,     1'b0, 1'b0);
        runDirected("add_2342",      32'd2342,  32'd4348345, 1'b0, 32'd4350687, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        runDirected("wrap", 32'd4294967290, 32'd4294967290, 1'b0, 32'hFFFF_FFF4, 1'b1, 1'b0);
    endtask

    task automatic test_carry_in();
        runDirected("cin_ripple", 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);
        runDirected("cin_small",  32'd7,         32'd8, 1'b1, 32'd16, 1'b0, 1'b0);
    endtask

    task automatic test_overflow();
        runDirected("signed_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        runDirected("neg_ovf",    32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W:0]   s;
        logic         ov;
        logic [W+1:0] e;
        for (int i = 0; i < 100; i++) begin
            a   = $urandom;
            b   = $urandom;
            cin = 1'($urandom_range(0, 1));
            s   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            ov  = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
            pushOp(a, b, cin, s[W-1:0], s[W], ov);
            @(posedge clk);
            #1;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL b2b_queue[%0d]: scoreboard empty, required one entry", i);
            end else begin
                e = q.pop_front();
                if (resultado !== e[W-1:0] || carryOut !== e[W]) begin
                    errors++;
                    $display("FAIL b2b[%0d]: resultado=%h carryOut=%b, required %h/%b",
                             i, resultado, carryOut, e[W-1:0], e[W]);
                end
`ifdef SUMADOR_FLAGS_EN
                checks++;
                if (overflow !== e[W+1] || zero !== (e[W-1:0] == '0) || negative !== e[W-1]) begin
                    errors++;
                    $display("FAIL b2b_flags[%0d]: ovf/zero/neg=%b%b%b, required %b%b%b", i,
                             overflow, zero, negative, e[W+1], (e[W-1:0] == '0), e[W-1]);
                end
`endif
            end
            if (i == 60) begin
                // Asynchronous reset mid-stream, away from any clock edge.
                #1;
                rst_n = 1'b0;
                #1;
                checks++;
                if (resultado !== '0 || carryOut !== 1'b0) begin
                    errors++;
                    $display("FAIL midrun_reset: resultado=%h carryOut=%b, required 0/0", resultado, carryOut);
                end
`ifdef SUMADOR_FLAGS_EN
                checks++;
                if ({overflow, zero, negative} !== 3'b000) begin
                    errors++;
                    $display("FAIL midrun_reset_flags: ovf/zero/neg=%b, required 000",
                             {overflow, zero, negative});
                end
`endif
                q.delete();
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        datoA   = '0;
        datoB   = '0;
        carryIn = 1'b0;
        #2;
        checks++;
        if (resultado !== '0 || carryOut !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: resultado=%h carryOut=%b, required 0/0", resultado, carryOut);
        end
        test_reset();
        test_basic();
        test_wrap();
        test_carry_in();
`ifdef SUMADOR_FLAGS_EN
        test_overflow();
`endif
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
